// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the graphic-LCD bus responder: opcodes, FSM states, address packing.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lcd_bus_pkg;

  // Instruction opcodes as mask/value pairs: (db & MASK) == VAL selects the instruction.
  localparam logic [7:0] OP_DISP_MASK  = 8'hFE;
  localparam logic [7:0] OP_DISP_VAL   = 8'h3E;  // 0x3E off, 0x3F on
  localparam logic [7:0] OP_SETY_MASK  = 8'hC0;
  localparam logic [7:0] OP_SETY_VAL   = 8'h40;
  localparam logic [7:0] OP_SETX_MASK  = 8'hF8;
  localparam logic [7:0] OP_SETX_VAL   = 8'hB8;
  localparam logic [7:0] OP_START_MASK = 8'hC0;
  localparam logic [7:0] OP_START_VAL  = 8'hC0;

  // Transaction FSM state encoding.
  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE     = 3'd0;
  localparam fsm_state_t ST_DECODE   = 3'd1;
  localparam fsm_state_t ST_WR0      = 3'd2;
  localparam fsm_state_t ST_WR1      = 3'd3;
  localparam fsm_state_t ST_RD_ADDR  = 3'd4;
  localparam fsm_state_t ST_RD_LATCH = 3'd5;

  // Frame-buffer address layout: {chip, page[2:0], y[5:0]}.
  function automatic logic [9:0] fb_addr_pack(input logic chip, input logic [2:0] page,
                                              input logic [5:0] y);
    return {chip, page, y};
  endfunction

  // Status byte: {busy, 0, display-off, reset, 0000}; busy and reset are never set here.
  function automatic logic [7:0] status_byte(input logic disp_on);
    return {2'b00, ~disp_on, 5'b00000};
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// LCD driver-to-panel bus: enable strobe, control, chip selects, and bidirectional data halves.
// Latency: n/a (wiring only).
// Backpressure: none; the bus is strobe-timed with no handshake.
interface lcd_bus_responder_if;
  logic       lcd_en_i;
  logic       lcd_rw_i;
  logic       lcd_dori_i;
  logic [1:0] lcd_cs_i;
  logic [7:0] lcd_db_i;
  logic [7:0] lcd_db_o;
  logic       lcd_db_oe_o;

  // master = LCD driver side, slave = panel/responder side
  modport master (
    output lcd_en_i, lcd_rw_i, lcd_dori_i, lcd_cs_i, lcd_db_i,
    input  lcd_db_o, lcd_db_oe_o
  );
  modport slave (
    input  lcd_en_i, lcd_rw_i, lcd_dori_i, lcd_cs_i, lcd_db_i,
    output lcd_db_o, lcd_db_oe_o
  );
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for all LCD bus inputs (moved in lockstep) with enable rise/fall detect.
// Latency: 2 clk to the s2 copies; edge pulses are valid while s1 and s2 disagree.
// Backpressure: none.
// Ports: i_en/i_rw/i_dori/i_cs/i_db raw bus in; o_* = s2 copies; o_rise/o_fall edge pulses.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_rw,
  input  logic       i_dori,
  input  logic [1:0] i_cs,
  input  logic [7:0] i_db,
  output logic       o_rw,
  output logic       o_dori,
  output logic [1:0] o_cs,
  output logic [7:0] o_db,
  output logic       o_rise,
  output logic       o_fall
);
  // Packed as {en, rw, dori, cs[1:0], db[7:0]} so every bit shares the same two stages.
  logic [12:0] r_s1;
  logic [12:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {i_en, i_rw, i_dori, i_cs, i_db};
      r_s2 <= r_s1;
    end
  end

  assign o_rw   = r_s2[11];
  assign o_dori = r_s2[10];
  assign o_cs   = r_s2[9:8];
  assign o_db   = r_s2[7:0];
  assign o_fall = r_s2[12] & ~r_s1[12];
  assign o_rise = ~r_s2[12] & r_s1[12];
endmodule

// File: rtl/lcd_bus_responder.sv
// Two-chip 128x64 LCD panel responder: decodes bus transactions into chip state and frame-buffer traffic.
// Latency: instr 2 clk after fall detect; fb write 2 (chip1 of dual write 3); read latch 4; read drive 1 clk after rise detect.
// Backpressure: none; edges arriving while the FSM is busy are dropped and flagged on cmd_err_o.
// Ports: clk/rst; bus (slave modport); fb_we_o/fb_addr_o/fb_wdata_o/fb_rdata_i frame RAM;
//        disp_on_o, start_line0_o/start_line1_o per-chip state; cmd_err_o error pulse.
module lcd_bus_responder
  import lcd_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  lcd_bus_responder_if.slave bus,
  output logic               fb_we_o,
  output logic [9:0]         fb_addr_o,
  output logic [7:0]         fb_wdata_o,
  input  logic [7:0]         fb_rdata_i,
  output logic [1:0]         disp_on_o,
  output logic [5:0]         start_line0_o,
  output logic [5:0]         start_line1_o,
  output logic               cmd_err_o
);
  // synchronized bus
  logic       w_rw, w_dori, w_rise, w_fall;
  logic [1:0] w_cs;
  logic [7:0] w_db;

  lcd_bus_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_en   (bus.lcd_en_i),
    .i_rw   (bus.lcd_rw_i),
    .i_dori (bus.lcd_dori_i),
    .i_cs   (bus.lcd_cs_i),
    .i_db   (bus.lcd_db_i),
    .o_rw   (w_rw),
    .o_dori (w_dori),
    .o_cs   (w_cs),
    .o_db   (w_db),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  fsm_state_t      r_state;
  logic            r_rw, r_dori;
  logic [1:0]      r_cs;
  logic [7:0]      r_db;
  logic [1:0]      r_disp_on;
  logic [1:0][5:0] r_y;
  logic [1:0][2:0] r_page;
  logic [1:0][5:0] r_start;
  logic [7:0]      r_latch;
  logic [7:0]      r_db_o;
  logic            r_db_oe;
  logic            r_cmd_err;

  logic       w_chip, w_fb_we;
  logic [9:0] w_fb_addr;
  logic       w_op_disp, w_op_sety, w_op_setx, w_op_start, w_op_legal;

  // WR1 is always the chip1 half of a dual write; otherwise the single selected chip.
  assign w_chip    = (r_state == ST_WR1) || (r_cs == 2'b10);
  assign w_fb_we   = (r_state == ST_WR0) || (r_state == ST_WR1);
  assign w_fb_addr = fb_addr_pack(w_chip, r_page[w_chip], r_y[w_chip]);

  assign w_op_disp  = (r_db & OP_DISP_MASK)  == OP_DISP_VAL;
  assign w_op_sety  = (r_db & OP_SETY_MASK)  == OP_SETY_VAL;
  assign w_op_setx  = (r_db & OP_SETX_MASK)  == OP_SETX_VAL;
  assign w_op_start = (r_db & OP_START_MASK) == OP_START_VAL;
  assign w_op_legal = w_op_disp | w_op_sety | w_op_setx | w_op_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rw      <= 1'b0;
      r_dori    <= 1'b0;
      r_cs      <= 2'b00;
      r_db      <= 8'h00;
      r_disp_on <= 2'b00;
      r_y       <= '0;
      r_page    <= '0;
      r_start   <= '0;
      r_latch   <= 8'h00;
      r_db_o    <= 8'h00;
      r_db_oe   <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;

      // Read drive: start on rise for a single-chip read, release on any fall.
      if (w_fall) begin
        r_db_oe <= 1'b0;
      end
      if (w_rise && (r_state == ST_IDLE) && w_rw && (w_cs[0] ^ w_cs[1])) begin
        r_db_oe <= 1'b1;
        r_db_o  <= w_dori ? r_latch : status_byte(r_disp_on[w_cs[1]]);
      end
      if ((w_rise || w_fall) && (r_state != ST_IDLE)) begin
        r_cmd_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_rw    <= w_rw;
            r_dori  <= w_dori;
            r_cs    <= w_cs;
            r_db    <= w_db;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_state <= ST_IDLE;
          if (r_cs != 2'b00) begin
            if (!r_rw && !r_dori) begin
              if (!w_op_legal) begin
                r_cmd_err <= 1'b1;
              end else begin
                for (int c = 0; c < 2; c++) begin
                  if (r_cs[c]) begin
                    if (w_op_disp)       r_disp_on[c] <= r_db[0];
                    else if (w_op_sety)  r_y[c]       <= r_db[5:0];
                    else if (w_op_setx)  r_page[c]    <= r_db[2:0];
                    else                 r_start[c]   <= r_db[5:0];
                  end
                end
              end
            end else if (!r_rw) begin
              r_state <= ST_WR0;
            end else if (r_cs == 2'b11) begin
              r_cmd_err <= 1'b1;  // a read cannot target both chips
            end else if (r_dori) begin
              r_state <= ST_RD_ADDR;
            end
          end
        end
        ST_WR0: begin
          r_y[w_chip] <= r_y[w_chip] + 6'd1;
          r_state     <= (r_cs == 2'b11) ? ST_WR1 : ST_IDLE;
        end
        ST_WR1: begin
          r_y[1]  <= r_y[1] + 6'd1;
          r_state <= ST_IDLE;
        end
        ST_RD_ADDR: begin
          r_state <= ST_RD_LATCH;
        end
        ST_RD_LATCH: begin
          // Address stays presented here, so y only moves after the RAM has answered.
          r_latch     <= fb_rdata_i;
          r_y[w_chip] <= r_y[w_chip] + 6'd1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fb_we_o       = w_fb_we;
  assign fb_addr_o     = (w_fb_we || (r_state == ST_RD_ADDR) || (r_state == ST_RD_LATCH)) ? w_fb_addr : 10'h000;
  assign fb_wdata_o    = w_fb_we ? r_db : 8'h00;
  assign disp_on_o     = r_disp_on;
  assign start_line0_o = r_start[0];
  assign start_line1_o = r_start[1];
  assign cmd_err_o     = r_cmd_err;
  assign bus.lcd_db_o    = r_db_o;
  assign bus.lcd_db_oe_o = r_db_oe;
endmodule
